// File: rtl/sr_skew_pkg.sv
// Package for the sr_skew staircase delay line.
//   sr_mode_e      : SR_SKEW staggers lanes (lane i deepest at the top),
//                    SR_DESKEW mirrors the staircase to realign a wavefront.
//   sr_lane_depth  : number of register stages for a given lane.
package sr_pkg;

  typedef enum logic {
    SR_SKEW   = 1'b0,
    SR_DESKEW = 1'b1
  } sr_mode_e;

  function automatic int sr_lane_depth(int lane, int n_lanes, int base, int mode);
    return (mode == int'(SR_DESKEW)) ? (base + n_lanes - 1 - lane) : (base + lane);
  endfunction

endpackage

// File: rtl/sr_skew_lane.sv
// Single valid-tagged delay lane used by sr_skew.
// Optional feature macro: SR_SKEW_ZERO_FILL_EN (zero data outside valid beats,
// data stages reset/flushed to 0).
// Ports:
//   clk, rst_n       clock, async active-low reset
//   i_en             advance enable; 0 holds every stage and gates o_vld
//   i_flush          sync clear of all valid stages (priority over i_en)
//   i_vld, i_dat     lane input beat
//   o_vld, o_dat     lane output beat
//   o_busy           any valid bit held in this lane
// DEPTH=0 collapses the lane to a combinational wire with no state.
module sr_lane #(
  parameter int DEPTH     = 1,
  parameter int DAT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_en,
  input  logic                 i_flush,
  input  logic                 i_vld,
  input  logic [DAT_WIDTH-1:0] i_dat,
  output logic                 o_vld,
  output logic [DAT_WIDTH-1:0] o_dat,
  output logic                 o_busy
);

  generate
    if (DEPTH == 0) begin : g_wire
      // No state here, so clock, reset and flush have nothing to act on.
      logic unused_ok;
      assign unused_ok = ^{clk, rst_n, i_flush};

      assign o_vld  = i_vld & i_en;
`ifdef SR_SKEW_ZERO_FILL_EN
      assign o_dat  = o_vld ? i_dat : '0;
`else
      assign o_dat  = i_dat;
`endif
      assign o_busy = 1'b0;
    end else begin : g_pipe
      logic [DEPTH-1:0]                vld_q, vld_d;
      logic [DEPTH-1:0][DAT_WIDTH-1:0] dat_q, dat_d;

      always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (i_flush) begin
          vld_d = '0;
`ifdef SR_SKEW_ZERO_FILL_EN
          dat_d = '0;
`endif
        end else if (i_en) begin
          // Bubbles shift along with valid beats so every slot keeps its timing.
          vld_d[0] = i_vld;
          dat_d[0] = i_dat;
          for (int k = 1; k < DEPTH; k++) begin
            vld_d[k] = vld_q[k-1];
            dat_d[k] = dat_q[k-1];
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_q <= '0;
        else        vld_q <= vld_d;
      end

`ifdef SR_SKEW_ZERO_FILL_EN
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dat_q <= '0;
        else        dat_q <= dat_d;
      end
`else
      always_ff @(posedge clk) begin
        dat_q <= dat_d;
      end
`endif

      // Gating with i_en keeps a held beat from being counted twice during a stall.
      assign o_vld  = vld_q[DEPTH-1] & i_en;
`ifdef SR_SKEW_ZERO_FILL_EN
      assign o_dat  = o_vld ? dat_q[DEPTH-1] : '0;
`else
      assign o_dat  = dat_q[DEPTH-1];
`endif
      assign o_busy = |vld_q;
    end
  endgenerate

endmodule

// File: rtl/sr_skew.sv
// sr_skew: multi-lane valid-tagged delay line forming a latency staircase.
// MODE=0 skews operands into a systolic array edge, MODE=1 deskews outputs.
// Optional feature macro: SR_SKEW_ZERO_FILL_EN (see sr_lane).
// Ports:
//   clk, rst_n            clock, async active-low reset
//   i_en                  advance enable; 0 stalls every lane
//   i_flush               sync drop of all in-flight beats
//   i_dat_vld, i_dat      per-lane input beat
//   o_dat_vld, o_dat      per-lane output beat
//   o_busy                any valid bit held in any stage
module sr_skew
  import sr_pkg::*;
#(
  parameter int N_LANES    = 4,
  parameter int DAT_WIDTH  = 16,
  parameter int BASE_DEPTH = 0,
  parameter int MODE       = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_en,
  input  logic                              i_flush,
  input  logic [N_LANES-1:0]                i_dat_vld,
  input  logic [N_LANES-1:0][DAT_WIDTH-1:0] i_dat,
  output logic [N_LANES-1:0]                o_dat_vld,
  output logic [N_LANES-1:0][DAT_WIDTH-1:0] o_dat,
  output logic                              o_busy
);

  logic [N_LANES-1:0] lane_busy;

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    localparam int LANE_DEPTH = sr_lane_depth(g, N_LANES, BASE_DEPTH, MODE);

    sr_lane #(
      .DEPTH    (LANE_DEPTH),
      .DAT_WIDTH(DAT_WIDTH)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (i_en),
      .i_flush(i_flush),
      .i_vld  (i_dat_vld[g]),
      .i_dat  (i_dat[g]),
      .o_vld  (o_dat_vld[g]),
      .o_dat  (o_dat[g]),
      .o_busy (lane_busy[g])
    );
  end

  assign o_busy = |lane_busy;

endmodule
